// File: rtl/uart_echo_responder_if.sv
// Handshake bundle between basic_uart (rx outputs / tx inputs) and the echo responder.
// RESP_STATS_EN adds the rx_count / drop_count statistics signals.
interface uart_echo_responder_if #(
  parameter int ADDR_W = 3
);
  logic [7:0]      rx_data;
  logic            rx_enable;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            tx_enable;
  logic [ADDR_W:0] fifo_level;
  logic            overflow;
  logic [7:0]      last_rx;
`ifdef RESP_STATS_EN
  logic [15:0]     rx_count;
  logic [15:0]     drop_count;
`endif

  // slave: the responder; master: the UART / bench side
  modport slave (
    input  rx_data, rx_enable, tx_ready,
    output tx_data, tx_enable, fifo_level, overflow, last_rx
`ifdef RESP_STATS_EN
    , output rx_count, drop_count
`endif
  );

  modport master (
    output rx_data, rx_enable, tx_ready,
    input  tx_data, tx_enable, fifo_level, overflow, last_rx
`ifdef RESP_STATS_EN
    , input rx_count, drop_count
`endif
  );
endinterface

// File: rtl/uart_echo_responder.sv
// Far-end UART echo: queues received bytes in a FIFO and relaunches them one at a time.
// Optional RESP_STATS_EN adds saturating rx_count / drop_count counters.
module uart_echo_responder #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  uart_echo_responder_if.slave io
);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [7:0]        tx_data_q, tx_data_d, last_rx_q, last_rx_d;
  logic              tx_en_q, tx_en_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full, empty, pop, push, drop;

  assign full  = (level_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign pop   = (state_q == IDLE) && io.tx_ready && !empty;
  // a full FIFO still takes the byte when the head leaves in the same cycle
  assign push  = io.rx_enable && (!full || pop);
  assign drop  = io.rx_enable && full && !pop;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    tx_data_d = tx_data_q;
    last_rx_d = last_rx_q;
    ovf_d     = ovf_q | drop;
    cnt_d     = cnt_q;

    if (io.rx_enable) last_rx_d = io.rx_data;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: if (pop) begin
        tx_data_d = mem_q[rd_ptr_q];
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // a UART that never goes busy is treated as having sent the byte
        if (!io.tx_ready)                          state_d = WAIT_DONE;
        else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) state_d = IDLE;
        else                                       cnt_d   = cnt_q + 1'b1;
      end
      WAIT_DONE: if (io.tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_en_d = (state_d == LAUNCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
      last_rx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ovf_q     <= ovf_d;
      last_rx_q <= last_rx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io.rx_data;
  end

  assign io.tx_data    = tx_data_q;
  assign io.tx_enable  = tx_en_q;
  assign io.fifo_level = level_q;
  assign io.overflow   = ovf_q;
  assign io.last_rx    = last_rx_q;

`ifdef RESP_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (io.rx_enable && rx_cnt_q != 16'hFFFF) rx_cnt_d   = rx_cnt_q + 1'b1;
    if (drop && drop_cnt_q != 16'hFFFF)       drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign io.rx_count   = rx_cnt_q;
  assign io.drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: echo latency, ordering, overflow, full push+pop,
// busy timeout and asynchronous reset mid-transfer.
module tb_uart_echo_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   txcnt    = 0;

  uart_echo_responder_if #(.ADDR_W(3)) io();

  uart_echo_responder #(.FIFO_DEPTH(8), .ADDR_W(3), .BUSY_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (io.tx_enable === 1'b1) txcnt++;

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    io.rx_data   = b;
    io.rx_enable = 1'b1;
    tick();
    io.rx_enable = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_tx(input string tag);
    int k;
    k = 0;
    while (io.tx_enable !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_seen"}, {15'd0, io.tx_enable}, 16'd1);
  endtask

  // UART model: goes busy for two cycles after each launch
  task automatic serve(input logic [7:0] exp, input string tag);
    wait_tx(tag);
    chk({tag, "_data"}, {8'd0, io.tx_data}, {8'd0, exp});
    io.tx_ready = 1'b0;
    tick();
    tick();
    io.tx_ready = 1'b1;
    tick();
  endtask

  initial begin
    int t0, base;
    reset        = 1'b1;
    io.rx_data   = 8'h00;
    io.rx_enable = 1'b0;
    io.tx_ready  = 1'b1;
    tick(); tick();
    chk("rst_tx_en",  {15'd0, io.tx_enable}, 16'd0);
    chk("rst_tx_data",{8'd0, io.tx_data},    16'd0);
    chk("rst_level",  {12'd0, io.fifo_level},16'd0);
    chk("rst_ovf",    {15'd0, io.overflow},  16'd0);
    chk("rst_last_rx",{8'd0, io.last_rx},    16'd0);
    reset = 1'b0;
    tick();

    // single echo: pulse in cycle N, launch in N+2
    send(8'hA5);
    chk("echo_n1_en",    {15'd0, io.tx_enable}, 16'd0);
    chk("echo_n1_level", {12'd0, io.fifo_level},16'd1);
    chk("echo_last_rx",  {8'd0, io.last_rx},    16'h00A5);
    tick();
    chk("echo_n2_en",    {15'd0, io.tx_enable}, 16'd1);
    chk("echo_n2_data",  {8'd0, io.tx_data},    16'h00A5);
    chk("echo_n2_level", {12'd0, io.fifo_level},16'd0);
    io.tx_ready = 1'b0;
    tick();
    chk("echo_n3_en",    {15'd0, io.tx_enable}, 16'd0);
    tick();
    io.tx_ready = 1'b1;
    tick(); tick();
    chk("echo_count",    16'(txcnt), 16'd1);

    // ordering with a busy UART
    io.tx_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33);
    tick();
    chk("ord_level", {12'd0, io.fifo_level}, 16'd3);
    chk("ord_no_tx", 16'(txcnt), 16'd1);
    io.tx_ready = 1'b1;
    serve(8'h11, "ord0");
    serve(8'h22, "ord1");
    serve(8'h33, "ord2");
    tick(); tick(); tick();
    chk("ord_count", 16'(txcnt), 16'd4);
    chk("ord_level_end", {12'd0, io.fifo_level}, 16'd0);

    // overflow: nine bytes into an eight-deep FIFO
    pulse_reset();
    base = txcnt;
    io.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(i));
    chk("ovf_level",   {12'd0, io.fifo_level}, 16'd8);
    chk("ovf_flag",    {15'd0, io.overflow},   16'd1);
    chk("ovf_last_rx", {8'd0, io.last_rx},     16'h0008);
`ifdef RESP_STATS_EN
    chk("ovf_rx_count",   io.rx_count,   16'd9);
    chk("ovf_drop_count", io.drop_count, 16'd1);
`endif
    io.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) serve(8'(i), "ovf_tx");
    for (int i = 0; i < 25; i++) tick();
    chk("ovf_count",     16'(txcnt - base), 16'd8);
    chk("ovf_last_sent", {8'd0, io.tx_data}, 16'h0007);
    chk("ovf_sticky",    {15'd0, io.overflow}, 16'd1);

    // full FIFO with push and pop in the same cycle
    pulse_reset();
    io.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
    chk("fpp_full", {12'd0, io.fifo_level}, 16'd8);
    io.tx_ready  = 1'b1;
    io.rx_data   = 8'hC3;
    io.rx_enable = 1'b1;
    tick();
    io.rx_enable = 1'b0;
    chk("fpp_level", {12'd0, io.fifo_level}, 16'd8);
    chk("fpp_ovf",   {15'd0, io.overflow},   16'd0);
    for (int i = 0; i < 8; i++) serve(8'h40 + 8'(i), "fpp_tx");
    serve(8'hC3, "fpp_c3");
    chk("fpp_empty", {12'd0, io.fifo_level}, 16'd0);
    chk("fpp_ovf_end", {15'd0, io.overflow}, 16'd0);

    // busy timeout: tx_ready never falls
    pulse_reset();
    io.tx_ready = 1'b0;
    send(8'h51); send(8'h52);
    io.tx_ready = 1'b1;
    wait_tx("to_first");
    chk("to_first_data", {8'd0, io.tx_data}, 16'h0051);
    t0 = cyc;
    tick();
    serve(8'h52, "to_second");
    chk("to_gap", 16'(cyc - t0 - 3), 16'd18);

    // asynchronous reset while in WAIT_DONE with three bytes queued
    pulse_reset();
    io.tx_ready = 1'b0;
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    io.tx_ready = 1'b1;
    wait_tx("ar_launch");
    chk("ar_data", {8'd0, io.tx_data}, 16'h0061);
    io.tx_ready = 1'b0;
    tick(); tick();
    chk("ar_level_pre", {12'd0, io.fifo_level}, 16'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_tx_data", {8'd0, io.tx_data},     16'd0);
    chk("ar_level",   {12'd0, io.fifo_level}, 16'd0);
    chk("ar_last_rx", {8'd0, io.last_rx},     16'd0);
    chk("ar_tx_en",   {15'd0, io.tx_enable},  16'd0);
    tick();
    io.tx_ready = 1'b1;
    reset = 1'b0;
    base = txcnt;
    for (int i = 0; i < 10; i++) tick();
    chk("ar_quiet", 16'(txcnt - base), 16'd0);
    send(8'h7E);
    serve(8'h7E, "ar_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
